// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Brief    : Two-port round-robin arbiter for one single-port sync SRAM, with
//            capped locked bursts. Optional perf counters: SRAM_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              i_req_valid,
    output logic [1:0]              o_req_ready,
    input  logic [1:0]              i_req_we,
    input  logic [1:0]              i_req_lock,
    input  logic [2*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [2*DATA_WIDTH-1:0] i_req_wdata,
    output logic [1:0]              o_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_rsp_data,
    output logic                    o_sram_cs,
    output logic                    o_sram_we,
    output logic [ADDR_WIDTH-1:0]   o_sram_addr,
    output logic [DATA_WIDTH-1:0]   o_sram_din,
    input  logic [DATA_WIDTH-1:0]   i_sram_dout
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [15:0]             o_grant_cnt0,
    output logic [15:0]             o_grant_cnt1,
    output logic [15:0]             o_conflict_cnt
`endif
);

    localparam int            CW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] C_CNT_MAX = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } owner_t;

    owner_t        r_owner, w_owner_nxt, w_own_g;
    logic          r_last_grant, w_last_nxt;
    logic [CW-1:0] r_burst_cnt, w_cnt_nxt;
    logic [1:0]    r_rd_pend, w_rd_pend_nxt;
    logic          w_gnt_vld;
    logic          w_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_burst_cnt  <= '0;
            r_rd_pend    <= 2'b00;
        end else begin
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_nxt;
            r_burst_cnt  <= w_cnt_nxt;
            r_rd_pend    <= w_rd_pend_nxt;
        end
    end

    always_comb begin
        w_gnt_vld     = 1'b0;
        w_gnt         = 1'b0;
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last_grant;
        w_cnt_nxt     = r_burst_cnt;
        w_rd_pend_nxt = 2'b00;

        case (i_req_valid)
            2'b01: w_gnt_vld = 1'b1;
            2'b10: begin
                w_gnt_vld = 1'b1;
                w_gnt     = 1'b1;
            end
            2'b11: begin
                w_gnt_vld = 1'b1;
                // A lock only wins contention until its count hits the cap.
                case (r_owner)
                    ST_OWN0: w_gnt = (r_burst_cnt == C_CNT_MAX);
                    ST_OWN1: w_gnt = (r_burst_cnt != C_CNT_MAX);
                    default: w_gnt = ~r_last_grant;
                endcase
            end
            default: ;
        endcase

        // Reset forces the handshake and SRAM strobes low immediately.
        if (rst) begin
            w_gnt_vld = 1'b0;
        end

        w_own_g = w_gnt ? ST_OWN1 : ST_OWN0;

        if (w_gnt_vld) begin
            w_last_nxt = w_gnt;
            if (i_req_lock[w_gnt]) begin
                w_owner_nxt = w_own_g;
                if (r_owner == w_own_g) begin
                    w_cnt_nxt = (r_burst_cnt == C_CNT_MAX) ? r_burst_cnt
                                                           : r_burst_cnt + CW'(1);
                end else begin
                    w_cnt_nxt = '0;
                end
            end else begin
                w_owner_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
            if (!i_req_we[w_gnt]) begin
                w_rd_pend_nxt = w_gnt ? 2'b10 : 2'b01;
            end
        end
    end

    assign o_req_ready = w_gnt_vld ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
    assign o_sram_cs   = w_gnt_vld;
    assign o_sram_we   = w_gnt_vld & i_req_we[w_gnt];
    assign o_sram_addr = w_gnt ? i_req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                               : i_req_addr[0 +: ADDR_WIDTH];
    assign o_sram_din  = w_gnt ? i_req_wdata[DATA_WIDTH +: DATA_WIDTH]
                               : i_req_wdata[0 +: DATA_WIDTH];
    assign o_rsp_valid = r_rd_pend;
    assign o_rsp_data  = i_sram_dout;

`ifdef SRAM_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_grant_cnt0   <= 16'h0000;
            o_grant_cnt1   <= 16'h0000;
            o_conflict_cnt <= 16'h0000;
        end else begin
            if (o_req_ready[0] && (o_grant_cnt0 != 16'hFFFF)) begin
                o_grant_cnt0 <= o_grant_cnt0 + 16'h0001;
            end
            if (o_req_ready[1] && (o_grant_cnt1 != 16'hFFFF)) begin
                o_grant_cnt1 <= o_grant_cnt1 + 16'h0001;
            end
            if ((i_req_valid == 2'b11) && (o_conflict_cnt != 16'hFFFF)) begin
                o_conflict_cnt <= o_conflict_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Brief    : Directed vector table plus corner-case sequences for sram_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int MB = 4;

    logic          clk;
    logic          rst;
    logic [1:0]    req_valid, req_we, req_lock;
    logic [3:0]    a0, a1;
    logic [7:0]    d0, d1;
    logic [1:0]    req_ready, rsp_valid;
    logic [7:0]    rsp_data;
    logic          sram_cs, sram_we;
    logic [3:0]    sram_addr;
    logic [7:0]    sram_din;
    logic [7:0]    sram_dout;
`ifdef SRAM_ARB_PERF_EN
    logic [15:0]   grant_cnt0, grant_cnt1, conflict_cnt;
`endif

    int checks;
    int errors;

    sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_req_lock  (req_lock),
        .i_req_addr  ({a1, a0}),
        .i_req_wdata ({d1, d0}),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_sram_cs   (sram_cs),
        .o_sram_we   (sram_we),
        .o_sram_addr (sram_addr),
        .o_sram_din  (sram_din),
        .i_sram_dout (sram_dout)
`ifdef SRAM_ARB_PERF_EN
        ,
        .o_grant_cnt0   (grant_cnt0),
        .o_grant_cnt1   (grant_cnt1),
        .o_conflict_cnt (conflict_cnt)
`endif
    );

    // Behavioural SRAM: registered read, write on cs&we.
    logic [7:0] mem [16] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                             8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) mem[sram_addr] <= sram_din;
            else         sram_dout      <= mem[sram_addr];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rb;
        logic [1:0] v, we, lk;
        logic [3:0] a0, a1;
        logic [7:0] d0, d1;
        logic [1:0] e_rdy, e_rv;
        logic [7:0] e_rdata;
        logic       e_cs, e_we;
        logic [3:0] e_addr;
        logic [7:0] e_din;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rb, input logic [1:0] v, input logic [1:0] we,
                       input logic [1:0] lk, input logic [3:0] xa0, input logic [3:0] xa1,
                       input logic [7:0] xd0, input logic [7:0] xd1,
                       input logic [1:0] e_rdy, input logic [1:0] e_rv, input logic [7:0] e_rdata,
                       input logic e_cs, input logic e_we, input logic [3:0] e_addr,
                       input logic [7:0] e_din);
        vec_t t;
        t.rb = rb; t.v = v; t.we = we; t.lk = lk; t.a0 = xa0; t.a1 = xa1;
        t.d0 = xd0; t.d1 = xd1; t.e_rdy = e_rdy; t.e_rv = e_rv; t.e_rdata = e_rdata;
        t.e_cs = e_cs; t.e_we = e_we; t.e_addr = e_addr; t.e_din = e_din;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                         input logic [3:0] xa0, input logic [3:0] xa1,
                         input logic [7:0] xd0, input logic [7:0] xd1);
        req_valid = v; req_we = we; req_lock = lk;
        a0 = xa0; a1 = xa1; d0 = xd0; d1 = xd1;
    endtask

    initial begin
        int waited;
        bit got;
        checks = 0;
        errors = 0;

        // Reset state, with both ports requesting during reset.
        rst = 1'b1;
        drive(2'b11, 2'b00, 2'b00, 4'd0, 4'd1, 8'h00, 8'h00);
        #3;
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_cs", 32'(sram_cs), 32'h0);
        chk("reset_we", 32'(sram_we), 32'h0);

        //  rb  v      we     lk     a0 a1 d0     d1     rdy    rv     rdata  cs    we    addr din
        // single port write then read of addr 3
        add(1, 2'b01, 2'b01, 2'b00, 3, 0, 8'hA5, 8'h00, 2'b01, 2'b00, 8'h00, 1'b1, 1'b1, 3, 8'hA5);
        add(0, 2'b01, 2'b00, 2'b00, 3, 0, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00, 1'b1, 1'b0, 3, 8'h00);
        add(0, 2'b00, 2'b00, 2'b00, 3, 0, 8'h00, 8'h00, 2'b00, 2'b01, 8'hA5, 1'b0, 1'b0, 3, 8'h00);
        // round-robin reads, p0 addr 0, p1 addr 1
        add(1, 2'b11, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00, 1'b1, 1'b0, 0, 8'h00);
        add(0, 2'b11, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b10, 2'b01, 8'h10, 1'b1, 1'b0, 1, 8'h00);
        add(0, 2'b11, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b01, 2'b10, 8'h11, 1'b1, 1'b0, 0, 8'h00);
        add(0, 2'b11, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b10, 2'b01, 8'h10, 1'b1, 1'b0, 1, 8'h00);
        add(0, 2'b00, 2'b00, 2'b00, 0, 1, 8'h00, 8'h00, 2'b00, 2'b10, 8'h11, 1'b0, 1'b0, 0, 8'h00);
        // write/read collision on addr 7
        add(1, 2'b11, 2'b01, 2'b00, 7, 7, 8'h3C, 8'h00, 2'b01, 2'b00, 8'h00, 1'b1, 1'b1, 7, 8'h3C);
        add(0, 2'b11, 2'b01, 2'b00, 7, 7, 8'h3C, 8'h00, 2'b10, 2'b00, 8'h00, 1'b1, 1'b0, 7, 8'h00);
        add(0, 2'b00, 2'b00, 2'b00, 7, 7, 8'h00, 8'h00, 2'b00, 2'b10, 8'h3C, 1'b0, 1'b0, 7, 8'h00);
        // burst cap: p1 locked reads addr 5, p0 reads addr 2
        add(1, 2'b10, 2'b00, 2'b10, 2, 5, 8'h00, 8'h00, 2'b10, 2'b00, 8'h00, 1'b1, 1'b0, 5, 8'h00);
        add(0, 2'b11, 2'b00, 2'b10, 2, 5, 8'h00, 8'h00, 2'b10, 2'b10, 8'h15, 1'b1, 1'b0, 5, 8'h00);
        add(0, 2'b11, 2'b00, 2'b10, 2, 5, 8'h00, 8'h00, 2'b10, 2'b10, 8'h15, 1'b1, 1'b0, 5, 8'h00);
        add(0, 2'b11, 2'b00, 2'b10, 2, 5, 8'h00, 8'h00, 2'b10, 2'b10, 8'h15, 1'b1, 1'b0, 5, 8'h00);
        add(0, 2'b11, 2'b00, 2'b10, 2, 5, 8'h00, 8'h00, 2'b01, 2'b10, 8'h15, 1'b1, 1'b0, 2, 8'h00);
        add(0, 2'b11, 2'b00, 2'b10, 2, 5, 8'h00, 8'h00, 2'b10, 2'b01, 8'h12, 1'b1, 1'b0, 5, 8'h00);
        add(0, 2'b11, 2'b00, 2'b10, 2, 5, 8'h00, 8'h00, 2'b10, 2'b10, 8'h15, 1'b1, 1'b0, 5, 8'h00);
        add(0, 2'b00, 2'b00, 2'b10, 2, 5, 8'h00, 8'h00, 2'b00, 2'b10, 8'h15, 1'b0, 1'b0, 2, 8'h00);

        foreach (vecs[i]) begin
            @(negedge clk);
            if (vecs[i].rb) begin
                rst = 1'b1;
                #1 rst = 1'b0;
            end
            drive(vecs[i].v, vecs[i].we, vecs[i].lk, vecs[i].a0, vecs[i].a1,
                  vecs[i].d0, vecs[i].d1);
            #2;
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
            if (vecs[i].e_rv != 2'b00)
                chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].e_rdata));
            chk($sformatf("v%0d_sram_cs", i), 32'(sram_cs), 32'(vecs[i].e_cs));
            chk($sformatf("v%0d_sram_we", i), 32'(sram_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_sram_addr", i), 32'(sram_addr), 32'(vecs[i].e_addr));
            if (vecs[i].e_cs && vecs[i].e_we)
                chk($sformatf("v%0d_sram_din", i), 32'(sram_din), 32'(vecs[i].e_din));
        end

        // Lock with idle competitor, then competitor arrives.
        @(negedge clk);
        rst = 1'b1;
        #1 rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c != 0) @(negedge clk);
            drive(2'b01, 2'b00, 2'b01, 4'd4, 4'd6, 8'h00, 8'h00);
            #2;
            chk($sformatf("lock_idle_c%0d_ready", c), 32'(req_ready), 32'h1);
        end
        @(negedge clk);
        drive(2'b11, 2'b00, 2'b01, 4'd4, 4'd6, 8'h00, 8'h00);
        got = 1'b0;
        waited = 0;
        for (int c = 0; c < MB; c++) begin
            if (c != 0) @(negedge clk);
            #2;
            if (req_ready[1]) begin
                got = 1'b1;
                break;
            end
            waited++;
        end
        chk("lock_release_granted", 32'(got), 32'h1);
        chk("lock_release_wait", 32'(waited), 32'h0);

        // Reset mid-read: the pending response must be discarded.
        @(negedge clk);
        rst = 1'b1;
        #1 rst = 1'b0;
        drive(2'b01, 2'b00, 2'b00, 4'd2, 4'd0, 8'h00, 8'h00);
        #2;
        chk("rstmid_accept_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rstmid_ready", 32'(req_ready), 32'h0);
        chk("rstmid_cs", 32'(sram_cs), 32'h0);
        chk("rstmid_we", 32'(sram_we), 32'h0);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 4'd2, 4'd0, 8'h00, 8'h00);
        rst = 1'b0;
        #2;
        chk("rstmid_after_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        #2;
        chk("rstmid_later_rsp_valid", 32'(rsp_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
